rx_descrambler: RTL
===================

RX_DESCRAMBLER -- requirements
Module: rx_descrambler

Interface
REQ-001 iClk  input  1  clock; all state updates on rising edge.
REQ-002 iRst  input  1  asynchronous active-high reset.
REQ-003 iStart  input  1  pulse marking the first SERVICE-field bit; the iData bit presented with iStart counts as bit 0 when iValid=1.
REQ-004 iValid  input  1  qualifies iData.
REQ-005 iData  input  1  scrambled received bit stream.
REQ-006 oValid  output  1  qualifies oData.
REQ-007 oData  output  1  descrambled bit.
REQ-008 oLocked  output  1  high once 7 seed bits are captured, until restart or reset.
REQ-009 oState  output  7 [7:1]  recovered LFSR contents at the lock instant; held until the next lock.
REQ-010 oSeedErr  output  1  recovered state was 7'b0000000; held until restart or reset.

Function
REQ-011 Polynomial x^7+x^4+1; keystream bit = LFSR[7]^LFSR[4], identical to the TX scrambler.
REQ-012 FSM states: IDLE, SYNC, RUN; reset state is IDLE.
REQ-013 IDLE: iValid bits ignored, oValid=0; iStart moves to SYNC.
REQ-014 SYNC: each valid bit shifts in as LFSR[k]<=LFSR[k-1], LFSR[1]<=iData; oData=0 for these bits, oValid=1.
REQ-015 On the 7th valid bit in SYNC: go to RUN; oLocked=1 and oState=LFSR (next-state value) on the following edge; oSeedErr=1 if that value is zero.
REQ-016 RUN: per valid bit, oData=iData^LFSR[7]^LFSR[4]; LFSR shifts with LFSR[1]<=LFSR[7]^LFSR[4].
REQ-017 Cycles with iValid=0 do not shift the LFSR, do not advance counters, and give oValid=0.
REQ-018 Latency: exactly one cycle; oValid/oData registered from iValid/iData.
REQ-019 iStart in any state restarts: LFSR cleared, counters cleared, oLocked and oSeedErr cleared, state SYNC; the concurrent valid bit is SYNC bit 0.
REQ-020 4-bit service counter counts valid bits 0..15 from iStart and saturates at 15; it never wraps.
REQ-021 RUN continues indefinitely until iStart or iRst; there is no end-of-frame input.

Reset
REQ-022 iRst asserted: LFSR=0, state=IDLE, counter=0, oValid=0, oData=0, oLocked=0, oState=0, oSeedErr=0, oSvcErr=0 (if present), all immediately and asynchronously.
REQ-023 Reset mid-SYNC or mid-RUN discards the partial seed; operation resumes only after a new iStart.

Configuration
REQ-024 Macro RX_DESCRAMBLER_SVC_CHECK_EN.
REQ-025 Defined: extra output port oSvcErr (1 bit); set when any descrambled SERVICE bit 7..15 is 1; cleared by iStart or reset; registered with the same latency as oData.
REQ-026 Undefined: oSvcErr port and checking logic are absent; all other behaviour is identical.

Verification
REQ-027 Seed 7'b1111111 TX scrambler feeding 16 zero SERVICE bits plus 64 random bits -> first 7 received bits are 0000111; oLocked rises and oState=7'b0000111; all 80 descrambled bits match the TX input.
REQ-028 Same stream with random iValid gaps (around 40% idle) -> identical descrambled sequence; oValid count equals the input valid count.
REQ-029 iStart reasserted mid-RUN with a new seed 7'b1011101 -> oLocked drops for 7 valid bits, then relocks with the new state; payload matches.
REQ-030 All-zero scrambled SERVICE (seed 0) -> oSeedErr=1 and oLocked=1.
REQ-031 iRst pulsed during SYNC after 3 bits -> all outputs 0 at once; valid bits without iStart -> oValid stays 0.
REQ-032 SVC_CHECK_EN defined, SERVICE bit 9 set to 1 before scrambling -> oSvcErr=1 one cycle after that bit; with the bit 0 -> oSvcErr stays 0.

Source files
------------

// File: rtl/rx_descrambler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_descrambler : x^7+x^4+1 receive descrambler, seed recovered from SERVICE
// Rev 1.0 | option RX_DESCRAMBLER_SVC_CHECK_EN adds oSvcErr
// ---------------------------------------------------------------------------
module rx_descrambler (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iValid,
  input  logic       iData,
  output logic       oValid,
  output logic       oData,
  output logic       oLocked,
  output logic [7:1] oState,
  output logic       oSeedErr
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
  ,
  output logic       oSvcErr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] c_LOCK_IDX = 4'd6;
  localparam logic [3:0] c_CNT_MAX  = 4'd15;

  state_t     state_q, state_d;
  logic [7:1] lfsr_q, lfsr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       data_q, data_d;
  logic       locked_q, locked_d;
  logic [7:1] seed_q, seed_d;
  logic       seed_err_q, seed_err_d;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
  logic       svc_err_q, svc_err_d;
  logic       svc_done_q, svc_done_d;
`endif

  logic       w_ks;
  logic [7:1] w_sync_next;

  assign w_ks        = lfsr_q[7] ^ lfsr_q[4];
  assign w_sync_next = {lfsr_q[6:1], iData};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      locked_q   <= 1'b0;
      seed_q     <= '0;
      seed_err_q <= 1'b0;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
      svc_err_q  <= 1'b0;
      svc_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      locked_q   <= locked_d;
      seed_q     <= seed_d;
      seed_err_q <= seed_err_d;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
      svc_err_q  <= svc_err_d;
      svc_done_q <= svc_done_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    data_d     = 1'b0;
    locked_d   = locked_q;
    seed_d     = seed_q;
    seed_err_d = seed_err_q;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
    svc_err_d  = svc_err_q;
    svc_done_d = svc_done_q;
`endif
    if (iStart) begin
      // The bit arriving with iStart is already SYNC bit 0.
      state_d    = SYNC;
      lfsr_d     = '0;
      cnt_d      = '0;
      locked_d   = 1'b0;
      seed_err_d = 1'b0;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
      svc_err_d  = 1'b0;
      svc_done_d = 1'b0;
`endif
      if (iValid) begin
        lfsr_d  = {6'b000000, iData};
        cnt_d   = 4'd1;
        valid_d = 1'b1;
      end
    end else if (iValid) begin
      case (state_q)
        SYNC: begin
          valid_d = 1'b1;
          lfsr_d  = w_sync_next;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == c_LOCK_IDX) begin
            state_d    = RUN;
            locked_d   = 1'b1;
            seed_d     = w_sync_next;
            seed_err_d = (w_sync_next == 7'd0);
          end
        end
        RUN: begin
          valid_d = 1'b1;
          data_d  = iData ^ w_ks;
          lfsr_d  = {lfsr_q[6:1], w_ks};
          if (cnt_q != c_CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
          end
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
          // Saturated counter cannot tell bit 15 from bit 16+, so flag the end.
          if (!svc_done_q) begin
            if (iData ^ w_ks) begin
              svc_err_d = 1'b1;
            end
            if (cnt_q == c_CNT_MAX) begin
              svc_done_d = 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign oValid   = valid_q;
  assign oData    = data_q;
  assign oLocked  = locked_q;
  assign oState   = seed_q;
  assign oSeedErr = seed_err_q;
`ifdef RX_DESCRAMBLER_SVC_CHECK_EN
  assign oSvcErr  = svc_err_q;
`endif

endmodule
`default_nettype wire
